// File: rtl/tetris_pkg.sv
// Shared constants, FSM state type and width helpers for the Tetris playfield logic.
package tetris_pkg;

  localparam int ROWS_DEF   = 24;
  localparam int COLS_DEF   = 10;
  localparam int CBITS_DEF  = 3;
  localparam int TOT_W_DEF  = 16;
  localparam int CELL_EMPTY = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    FILL    = 2'd2,
    DONE    = 2'd3
  } pf_state_t;

  // Ceiling log2, never narrower than one bit.
  function automatic int pf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/playfield_buffer_row_full_detect.sv
// Combinational full-row detector: high when every cell of the row holds a colour.
module row_full_detect
  import tetris_pkg::*;
#(
  parameter int COLS  = COLS_DEF,
  parameter int CBITS = CBITS_DEF
) (
  input  logic [COLS*CBITS-1:0] row_data,
  output logic                  full
);

  always_comb begin
    full = 1'b1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (row_data[c*CBITS +: CBITS] == CBITS'(CELL_EMPTY)) full = 1'b0;
    end
  end

endmodule

// File: rtl/playfield_buffer.sv
// Playfield row store with registered display read port, full-row detection
// and a line-clear/collapse pass with a start/busy/done handshake.
module playfield_buffer
  import tetris_pkg::*;
#(
  parameter  int ROWS  = ROWS_DEF,
  parameter  int COLS  = COLS_DEF,
  parameter  int CBITS = CBITS_DEF,
  parameter  int TOT_W = TOT_W_DEF,
  localparam int ROW_W = COLS * CBITS,
  localparam int RA_W  = pf_clog2(ROWS),
  localparam int LC_W  = pf_clog2(ROWS + 1)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             game_reset,
  input  logic             wr_en,
  input  logic [RA_W-1:0]  wr_row,
  input  logic [ROW_W-1:0] wr_data,
  input  logic [RA_W-1:0]  rd_row,
  output logic [ROW_W-1:0] rd_data,
  output logic [ROWS-1:0]  full_mask,
  input  logic             clear_start,
  output logic             clear_busy,
  output logic             clear_done,
  output logic [LC_W-1:0]  lines_cleared,
  output logic [TOT_W-1:0] total_lines
);

  localparam logic [RA_W-1:0] LAST_ROW = RA_W'(ROWS - 1);

  logic [ROW_W-1:0] rows_q [ROWS];
  logic [ROW_W-1:0] rows_d [ROWS];
  logic [ROW_W-1:0] rd_data_q, rd_data_d;
  pf_state_t        state_q, state_d;
  logic [RA_W-1:0]  src_q, src_d;
  logic [RA_W-1:0]  dst_q, dst_d;
  logic [LC_W-1:0]  cnt_q, cnt_d;
  logic [LC_W-1:0]  lines_q, lines_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [TOT_W:0]   total_sum;

  for (genvar r = 0; r < ROWS; r++) begin : g_det
    row_full_detect #(
      .COLS  (COLS),
      .CBITS (CBITS)
    ) u_det (
      .row_data (rows_q[r]),
      .full     (full_mask[r])
    );
  end

  always_comb begin
    rows_d    = rows_q;
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    total_d   = total_q;
    rd_data_d = (rd_row <= LAST_ROW) ? rows_q[rd_row] : '0;
    total_sum = {1'b0, total_q} + (TOT_W + 1)'(cnt_q);

    case (state_q)
      IDLE: begin
        if (wr_en && (wr_row <= LAST_ROW)) rows_d[wr_row] = wr_data;
        if (clear_start) begin
          state_d = COMPACT;
          src_d   = LAST_ROW;
          dst_d   = LAST_ROW;
          cnt_d   = '0;
        end
      end
      COMPACT: begin
        if (full_mask[src_q]) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          rows_d[dst_q] = rows_q[src_q];
          dst_d         = dst_q - 1'b1;
        end
        src_d = src_q - 1'b1;
        if (src_q == '0) state_d = (cnt_d != '0) ? FILL : DONE;
      end
      FILL: begin
        // Compaction leaves dst at cnt-1, so reaching row 0 marks the last fill.
        rows_d[dst_q] = '0;
        dst_d         = dst_q - 1'b1;
        if (dst_q == '0) state_d = DONE;
      end
      DONE: begin
        lines_d = cnt_q;
        total_d = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (game_reset) begin
      for (int unsigned r = 0; r < ROWS; r++) rows_d[r] = '0;
      state_d = IDLE;
      lines_d = '0;
      total_d = '0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int unsigned r = 0; r < ROWS; r++) rows_q[r] <= '0;
      rd_data_q <= '0;
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      lines_q   <= '0;
      total_q   <= '0;
    end else begin
      rows_q    <= rows_d;
      rd_data_q <= rd_data_d;
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      total_q   <= total_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign clear_busy    = (state_q != IDLE);
  assign clear_done    = (state_q == DONE) && !game_reset;
  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

endmodule

// File: tb/tb_playfield_buffer.sv
// Self-checking bench for playfield_buffer: vector table, directed passes and
// randomized fields compared against a row-list model of the collapse.
module tb_playfield_buffer;

  logic        clk = 1'b0;
  logic        reset_reset, game_reset, wr_en, clear_start;
  logic [4:0]  wr_row, rd_row;
  logic [29:0] wr_data;

  logic [29:0] rd_data, s_rd_data;
  logic [23:0] full_mask, s_full_mask;
  logic        busy, done, s_busy, s_done;
  logic [4:0]  lines, s_lines;
  logic [15:0] total;
  logic [3:0]  s_total;

  int checks = 0;
  int failures = 0;

  logic [29:0] m_rows [24];
  int          m_total = 0;

  always #5 clk = ~clk;

  playfield_buffer dut (
    .clk_clk (clk), .reset_reset (reset_reset), .game_reset (game_reset),
    .wr_en (wr_en), .wr_row (wr_row), .wr_data (wr_data),
    .rd_row (rd_row), .rd_data (rd_data), .full_mask (full_mask),
    .clear_start (clear_start), .clear_busy (busy), .clear_done (done),
    .lines_cleared (lines), .total_lines (total)
  );

  // Narrow accumulator instance so saturation is reachable in a short run.
  playfield_buffer #(.TOT_W (4)) dut_s (
    .clk_clk (clk), .reset_reset (reset_reset), .game_reset (game_reset),
    .wr_en (wr_en), .wr_row (wr_row), .wr_data (wr_data),
    .rd_row (rd_row), .rd_data (s_rd_data), .full_mask (s_full_mask),
    .clear_start (clear_start), .clear_busy (s_busy), .clear_done (s_done),
    .lines_cleared (s_lines), .total_lines (s_total)
  );

  typedef struct {
    logic [4:0]  row;
    logic [29:0] data;
    logic        exp_full;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] mk_row(input logic [2:0] colour);
    logic [29:0] v;
    for (int c = 0; c < 10; c++) v[c*3 +: 3] = colour;
    return v;
  endfunction

  function automatic logic is_full(input logic [29:0] row);
    for (int c = 0; c < 10; c++) if (row[c*3 +: 3] == 3'd0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [23:0] model_mask();
    logic [23:0] m;
    for (int r = 0; r < 24; r++) m[r] = is_full(m_rows[r]);
    return m;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Model of a pass: keep non-full rows in order, drop them to the bottom.
  task automatic model_pass(output int cnt);
    logic [29:0] keep[$];
    for (int r = 0; r < 24; r++) if (!is_full(m_rows[r])) keep.push_back(m_rows[r]);
    cnt = 24 - keep.size();
    for (int r = 0; r < 24; r++) m_rows[r] = (r < cnt) ? 30'd0 : keep[r - cnt];
    m_total += cnt;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 24; r++) m_rows[r] = '0;
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_write(input logic [4:0] r, input logic [29:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (r < 24) m_rows[r] = d;
  endtask

  task automatic check_field(input string tag);
    for (int r = 0; r < 24; r++) begin
      rd_row = 5'(r);
      @(negedge clk);
      chk({tag, "_rd"}, rd_data, m_rows[r]);
    end
    chk({tag, "_srd"}, s_rd_data, m_rows[23]);
    chk({tag, "_mask"}, full_mask, model_mask());
    chk({tag, "_smask"}, s_full_mask, model_mask());
  endtask

  task automatic do_game_reset();
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    model_clear();
    m_total = 0;
  endtask

  task automatic run_pass(input int inject, input string tag);
    int busy_n, done_n, done_at, k, cnt;
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; k = 0;
    while (busy === 1'b1 && k < 200) begin
      busy_n++;
      if (done === 1'b1) begin done_n++; done_at = busy_n; end
      if (s_busy !== 1'b1) chk({tag, "_sbusy"}, s_busy, 1);
      if (inject != 0 && busy_n == inject) begin
        wr_en = 1'b1; wr_row = 5'd0; wr_data = mk_row(3'd6); clear_start = 1'b1;
      end else begin
        wr_en = 1'b0; clear_start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    wr_en = 1'b0; clear_start = 1'b0;
    chk({tag, "_timeout"}, (k >= 200), 0);
    model_pass(cnt);
    chk({tag, "_busy_cycles"}, busy_n, 24 + cnt + 1);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_done_at"}, done_at, 24 + cnt + 1);
    chk({tag, "_lines"}, lines, cnt);
    chk({tag, "_slines"}, s_lines, cnt);
    chk({tag, "_total"}, total, sat(m_total, 16'hFFFF));
    chk({tag, "_stotal"}, s_total, sat(m_total, 15));
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, done}, 2'b00);
  endtask

  vec_t tbl [8];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, n, gr_done;
    logic [29:0] v;
    logic [4:0] r;

    reset_reset = 1'b1; game_reset = 1'b0; wr_en = 1'b0; clear_start = 1'b0;
    wr_row = '0; wr_data = '0; rd_row = '0;
    model_clear();
    #12;
    chk("reset_outputs", {rd_data, full_mask, busy, done, lines, total, s_total},
        '0);
    @(negedge clk);
    reset_reset = 1'b0;
    check_field("post_reset");
    chk("post_reset_busy", busy, 0);

    tbl[0] = '{5'd0,  mk_row(3'd7), 1'b1};
    tbl[1] = '{5'd5,  mk_row(3'd1) & ~30'h7, 1'b0};
    tbl[2] = '{5'd23, 30'h0, 1'b0};
    tbl[3] = '{5'd12, mk_row(3'd4) & ~(30'h7 << 27), 1'b0};
    tbl[4] = '{5'd7,  30'h3FFFFFFF, 1'b1};
    tbl[5] = '{5'd26, mk_row(3'd3), 1'b0};
    tbl[6] = '{5'd0,  30'h1, 1'b0};
    tbl[7] = '{5'd9,  30'o1234567123, 1'b1};
    for (int i = 0; i < 8; i++) begin
      do_write(tbl[i].row, tbl[i].data);
      rd_row = tbl[i].row;
      @(negedge clk);
      chk("vec_rd", rd_data, (tbl[i].row < 24) ? tbl[i].data : 30'd0);
      if (tbl[i].row < 24) chk("vec_full", full_mask[tbl[i].row], tbl[i].exp_full);
    end
    check_field("vec_field");

    do_game_reset();
    do_write(5'd23, mk_row(3'd1));
    do_write(5'd22, 30'h5);
    run_pass(0, "one_line");
    chk("one_line_row23", m_rows[23], 30'h5);
    check_field("one_line_field");

    do_write(5'd23, mk_row(3'd2));
    do_write(5'd22, mk_row(3'd3));
    do_write(5'd21, mk_row(3'd4));
    do_write(5'd20, mk_row(3'd5));
    do_write(5'd19, 30'h1);
    run_pass(0, "four_lines");
    chk("four_lines_mask", full_mask, 24'h0);
    check_field("four_lines_field");

    do_write(5'd22, mk_row(3'd6));
    do_write(5'd21, mk_row(3'd7));
    do_write(5'd4, 30'h3F);
    run_pass(10, "busy_inject");
    check_field("busy_inject_field");

    do_write(5'd10, mk_row(3'd2));
    do_write(5'd11, 30'h7);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (5) @(negedge clk);
    game_reset = 1'b1; wr_en = 1'b1; wr_row = 5'd3; wr_data = mk_row(3'd2);
    @(negedge clk);
    game_reset = 1'b0; wr_en = 1'b0;
    model_clear(); m_total = 0;
    chk("greset_state", {busy, done, lines, total, s_total, full_mask}, '0);
    gr_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) gr_done++;
      @(negedge clk);
    end
    chk("greset_no_done", gr_done, 0);
    check_field("greset_field");

    game_reset = 1'b1; wr_en = 1'b1; wr_row = 5'd4; wr_data = mk_row(3'd5);
    @(negedge clk);
    game_reset = 1'b0; wr_en = 1'b0;
    rd_row = 5'd4;
    @(negedge clk);
    chk("greset_drops_write", rd_data, 30'h0);

    for (int i = 10; i < 24; i++) do_write(5'(i), mk_row(3'd3));
    run_pass(0, "sat14");
    do_write(5'd23, mk_row(3'd1));
    do_write(5'd22, mk_row(3'd2));
    run_pass(0, "sat16");
    chk("sat16_stotal", s_total, 4'hF);
    do_write(5'd23, mk_row(3'd4));
    run_pass(0, "sat17");
    check_field("sat_field");

    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 10);
      for (int w = 0; w < n; w++) begin
        for (int c = 0; c < 10; c++)
          v[c*3 +: 3] = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        r = 5'($urandom_range(0, 27));
        do_write(r, v);
      end
      run_pass(0, "rand");
      check_field("rand_field");
    end

    for (int i = 20; i < 24; i++) do_write(5'(i), mk_row(3'd6));
    do_write(5'd2, 30'h2);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (25) @(negedge clk);
    chk("pre_async_busy", busy, 1);
    #2 reset_reset = 1'b1;
    #1;
    chk("async_reset", {rd_data, full_mask, busy, done, lines, total, s_total}, '0);
    @(negedge clk);
    reset_reset = 1'b0;
    model_clear(); m_total = 0;
    check_field("async_field");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
